// File: rtl/pong_score_fsm.sv
// Pong score keeper: serve delay, point scoring, win detection and restart.
// Every output is a flop, updated only on the rising clock edge.
module pong_score_fsm #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       left_miss,
  input  logic       right_miss,
  output logic [3:0] leftPlayerScore,
  output logic [3:0] rightPlayerScore,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic       point_scored,
  output logic       game_over,
  output logic       winner
);

  localparam int              CW     = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]      WIN    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    left_q, left_d, right_q, right_d;
  logic          ball_q, ball_d, dir_q, dir_d, point_q, point_d;
  logic          over_q, over_d, winner_q, winner_d;
  // Set when start was low last cycle; clears in reset so a start held
  // high through reset release cannot look like a fresh edge.
  logic          start_low_q;
  logic          start_edge;

  assign start_edge = start & start_low_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    right_d  = right_q;
    ball_d   = ball_q;
    dir_d    = dir_q;
    point_d  = 1'b0;
    over_d   = over_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        left_d   = '0;
        right_d  = '0;
        ball_d   = 1'b0;
        dir_d    = 1'b0;
        over_d   = 1'b0;
        winner_d = 1'b0;
        if (start_edge) begin
          state_d = SERVE;
          cnt_d   = RELOAD;
        end
      end
      SERVE: begin
        if (cnt_q == '0) begin
          state_d = PLAY;
          ball_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PLAY: begin
        if (left_miss || right_miss) begin
          ball_d  = 1'b0;
          state_d = SERVE;
          cnt_d   = RELOAD;
          // A simultaneous double miss is a dead ball: just re-serve.
          if (left_miss && !right_miss) begin
            right_d = right_q + 4'd1;
            point_d = 1'b1;
            dir_d   = 1'b0;
            if (right_d == WIN) begin
              state_d  = OVER;
              over_d   = 1'b1;
              winner_d = 1'b1;
            end
          end else if (right_miss && !left_miss) begin
            left_d  = left_q + 4'd1;
            point_d = 1'b1;
            dir_d   = 1'b1;
            if (left_d == WIN) begin
              state_d  = OVER;
              over_d   = 1'b1;
              winner_d = 1'b0;
            end
          end
        end
      end
      OVER: begin
        if (start_edge) begin
          left_d  = '0;
          right_d = '0;
          over_d  = 1'b0;
          dir_d   = ~winner_q;
          state_d = SERVE;
          cnt_d   = RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      ball_q      <= 1'b0;
      dir_q       <= 1'b0;
      point_q     <= 1'b0;
      over_q      <= 1'b0;
      winner_q    <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      ball_q      <= ball_d;
      dir_q       <= dir_d;
      point_q     <= point_d;
      over_q      <= over_d;
      winner_q    <= winner_d;
      start_low_q <= ~start;
    end
  end

  assign leftPlayerScore  = left_q;
  assign rightPlayerScore = right_q;
  assign ball_enable      = ball_q;
  assign serve_dir        = dir_q;
  assign point_scored     = point_q;
  assign game_over        = over_q;
  assign winner           = winner_q;

endmodule

// File: tb/tb_pong_score_fsm.sv
// Bench for pong_score_fsm: directed scenarios followed by random rallies
// checked against a simple score-keeping model of the game rules.
module tb_pong_score_fsm;

  logic       clk = 1'b0;
  logic       reset, start, left_miss, right_miss;
  logic [3:0] leftPlayerScore, rightPlayerScore;
  logic       ball_enable, serve_dir, point_scored, game_over, winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the game: scores, serve direction, game-over flag, winner.
  int L, R, sd, over, win;

  pong_score_fsm #(.WIN_SCORE(3), .SERVE_DELAY(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .left_miss(left_miss), .right_miss(right_miss),
    .leftPlayerScore(leftPlayerScore), .rightPlayerScore(rightPlayerScore),
    .ball_enable(ball_enable), .serve_dir(serve_dir),
    .point_scored(point_scored), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_scores(input string tag);
    check({tag, ".left"}, 32'(leftPlayerScore), L);
    check({tag, ".right"}, 32'(rightPlayerScore), R);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".left"}, 32'(leftPlayerScore), 0);
    check({tag, ".right"}, 32'(rightPlayerScore), 0);
    check({tag, ".ball"}, 32'(ball_enable), 0);
    check({tag, ".dir"}, 32'(serve_dir), 0);
    check({tag, ".point"}, 32'(point_scored), 0);
    check({tag, ".over"}, 32'(game_over), 0);
    check({tag, ".winner"}, 32'(winner), 0);
  endtask

  // Called one cycle after the event that starts a serve: the ball must
  // stay held for three more cycles and be released on the fourth.
  task automatic serve_wait(input string tag, input bit noise);
    for (int k = 1; k <= 4; k++) begin
      if (noise) begin
        left_miss  = 1'($urandom);
        right_miss = 1'($urandom);
        start      = 1'($urandom);
      end
      tick();
      if (k == 1) check({tag, ".point_clear"}, 32'(point_scored), 0);
      check({tag, ".ball"}, 32'(ball_enable), (k == 4) ? 1 : 0);
      check_scores(tag);
    end
    left_miss  = 1'b0;
    right_miss = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; left_miss = 1'b0; right_miss = 1'b0;
    L = 0; R = 0; sd = 0; over = 0; win = 0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    check_zero("post_reset");

    // First serve: start edge, ball released five cycles after the edge cycle.
    start = 1'b1;
    tick();
    check("start.ball_held", 32'(ball_enable), 0);
    serve_wait("first_serve", 1'b0);
    $display("txn first_serve: ball_enable=%0d scores %0d/%0d", ball_enable, leftPlayerScore, rightPlayerScore);

    // Right player misses: left scores.
    right_miss = 1'b1;
    tick();
    right_miss = 1'b0;
    L = 1;
    check_scores("right_miss");
    check("right_miss.point", 32'(point_scored), 1);
    check("right_miss.dir", 32'(serve_dir), 1);
    check("right_miss.ball", 32'(ball_enable), 0);
    serve_wait("right_miss_reserve", 1'b0);
    $display("txn right_miss: scores %0d/%0d serve_dir=%0d", leftPlayerScore, rightPlayerScore, serve_dir);

    // Double miss: dead ball.
    left_miss = 1'b1; right_miss = 1'b1;
    tick();
    left_miss = 1'b0; right_miss = 1'b0;
    check_scores("double_miss");
    check("double_miss.point", 32'(point_scored), 0);
    check("double_miss.dir", 32'(serve_dir), 1);
    check("double_miss.ball", 32'(ball_enable), 0);
    serve_wait("double_miss_reserve", 1'b0);
    $display("txn double_miss: scores %0d/%0d", leftPlayerScore, rightPlayerScore);

    // Three left misses: right reaches 3 and wins.
    for (int i = 1; i <= 3; i++) begin
      left_miss = 1'b1;
      tick();
      left_miss = 1'b0;
      R = i;
      check_scores("left_miss");
      check("left_miss.point", 32'(point_scored), 1);
      check("left_miss.dir", 32'(serve_dir), 0);
      check("left_miss.ball", 32'(ball_enable), 0);
      if (i < 3) serve_wait("left_miss_reserve", 1'b0);
      $display("txn left_miss %0d: scores %0d/%0d", i, leftPlayerScore, rightPlayerScore);
    end
    check("win.game_over", 32'(game_over), 1);
    check("win.winner", 32'(winner), 1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left_miss = 1'(i); right_miss = 1'(i >> 1);
      tick();
      check_scores("over_frozen");
      check("over_frozen.point", 32'(point_scored), 0);
      check("over_frozen.over", 32'(game_over), 1);
      check("over_frozen.ball", 32'(ball_enable), 0);
    end
    left_miss = 1'b0; right_miss = 1'b0;
    $display("txn game_over: winner=%0d scores %0d/%0d", winner, leftPlayerScore, rightPlayerScore);

    // Restart from OVER: loser (left) is served to.
    start = 1'b1;
    tick();
    L = 0; R = 0;
    check_scores("restart");
    check("restart.over", 32'(game_over), 0);
    check("restart.dir", 32'(serve_dir), 0);
    serve_wait("restart_serve", 1'b0);
    $display("txn restart: scores %0d/%0d serve_dir=%0d", leftPlayerScore, rightPlayerScore, serve_dir);

    // Random rallies against the model.
    sd = 0; over = 0; win = 0;
    for (int ev = 0; ev < 60; ev++) begin
      if (over != 0) begin
        start = 1'b0;
        repeat ($urandom_range(2, 4)) begin
          left_miss  = 1'($urandom);
          right_miss = 1'($urandom);
          tick();
          check_scores("rnd_over");
          check("rnd_over.over", 32'(game_over), 1);
          check("rnd_over.winner", 32'(winner), win);
          check("rnd_over.ball", 32'(ball_enable), 0);
        end
        left_miss = 1'b0; right_miss = 1'b0;
        start = 1'b1;
        tick();
        L = 0; R = 0; over = 0; sd = 1 - win;
        check_scores("rnd_restart");
        check("rnd_restart.over", 32'(game_over), 0);
        check("rnd_restart.dir", 32'(serve_dir), sd);
        serve_wait("rnd_restart_serve", 1'b1);
        $display("txn rnd %0d: restart serve_dir=%0d", ev, serve_dir);
      end else begin
        int kind;
        repeat ($urandom_range(0, 3)) begin
          start = 1'($urandom);
          tick();
          check("rnd_play.ball", 32'(ball_enable), 1);
          check_scores("rnd_play");
        end
        kind = $urandom_range(0, 2);
        left_miss  = (kind != 1);
        right_miss = (kind != 0);
        tick();
        if (kind == 0) begin R++; sd = 0; end
        if (kind == 1) begin L++; sd = 1; end
        if (L == 3 || R == 3) begin over = 1; win = (R == 3) ? 1 : 0; end
        check_scores("rnd_miss");
        check("rnd_miss.point", 32'(point_scored), (kind == 2) ? 0 : 1);
        check("rnd_miss.dir", 32'(serve_dir), sd);
        check("rnd_miss.ball", 32'(ball_enable), 0);
        check("rnd_miss.over", 32'(game_over), over);
        $display("txn rnd %0d: miss kind=%0d scores %0d/%0d", ev, kind, leftPlayerScore, rightPlayerScore);
        if (over != 0) begin
          left_miss = 1'b0; right_miss = 1'b0;
        end else begin
          serve_wait("rnd_reserve", 1'b1);
        end
      end
    end

    // Reset in whatever state the rallies left, then mid-SERVE with start held.
    reset = 1'b1; left_miss = 1'b0; right_miss = 1'b0;
    tick();
    check_zero("reset_mid_game");
    reset = 1'b0; start = 1'b0;
    tick();
    start = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_zero("reset_mid_serve");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("held_start.ball", 32'(ball_enable), 0);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    L = 0; R = 0;
    serve_wait("rearm_serve", 1'b0);
    $display("txn reset_mid_serve: ball_enable=%0d after rearm", ball_enable);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_score_fsm.md
PONG_SCORE_FSM -- requirements
Module: pong_score_fsm

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 9, score (1-9) that ends the game.
REQ-002 The block SHALL have parameter SERVE_DELAY, default 100000000, clk cycles the ball is held before each serve (≥1).
REQ-003 The block SHALL have port clk  input  1  system clock, sole clock domain.
REQ-004 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port start  input  1  debounced start switch level, edge-detected internally.
REQ-006 The block SHALL have port left_miss  input  1  one-cycle pulse from the graphics stage when the ball passes the left paddle.
REQ-007 The block SHALL have port right_miss  input  1  one-cycle pulse from the graphics stage when the ball passes the right paddle.
REQ-008 The block SHALL have port leftPlayerScore  output  4  left score, binary 0..WIN_SCORE, to the seven-segment display.
REQ-009 The block SHALL have port rightPlayerScore  output  4  right score, binary 0..WIN_SCORE, to the seven-segment display.
REQ-010 The block SHALL have port ball_enable  output  1  high only in PLAY; the graphics stage moves the ball only when high.
REQ-011 The block SHALL have port serve_dir  output  1  0 = serve toward left player, 1 = toward right.
REQ-012 The block SHALL have port point_scored  output  1  one-cycle pulse when a score increments.
REQ-013 The block SHALL have port game_over  output  1  high in OVER.
REQ-014 The block SHALL have port winner  output  1  0 = left won, 1 = right won; valid while game_over is high.

Function
REQ-015 All outputs SHALL be registered and change only on the rising edge of clk.
REQ-016 The block SHALL detect a start rising edge as start=1 this cycle and start=0 the previous cycle, using one register.
REQ-017 The state machine SHALL have states IDLE, SERVE, PLAY, OVER.
REQ-018 IDLE: all outputs held low/zero; on a start rising edge the block SHALL go to SERVE and load the delay counter with SERVE_DELAY-1.
REQ-019 SERVE: the counter SHALL decrement each cycle, and the cycle after it reads 0 the block SHALL be in PLAY with ball_enable=1; SERVE therefore lasts exactly SERVE_DELAY cycles.
REQ-020 SERVE: left_miss, right_miss and start SHALL be ignored.
REQ-021 PLAY, left_miss only: rightPlayerScore SHALL increment by 1, point_scored SHALL pulse, and serve_dir SHALL be 0, all one cycle after the miss.
REQ-022 PLAY, right_miss only: leftPlayerScore SHALL increment by 1, point_scored SHALL pulse, and serve_dir SHALL be 1, all one cycle after the miss.
REQ-023 PLAY, left_miss and right_miss in the same cycle: no score SHALL change, no point_scored pulse SHALL occur, serve_dir SHALL be unchanged, and the next state SHALL be SERVE.
REQ-024 After an increment, if the new score equals WIN_SCORE the next state SHALL be OVER with winner set to the scorer; otherwise the next state SHALL be SERVE with the counter reloaded.
REQ-025 ball_enable SHALL fall in the same cycle that the score updates.
REQ-026 PLAY: start edges SHALL be ignored.
REQ-027 OVER: game_over=1, ball_enable=0, and scores SHALL be frozen at their final values.
REQ-028 OVER, on a start rising edge: both scores SHALL clear to 0, game_over SHALL clear, serve_dir SHALL flip to face the loser, and the next state SHALL be SERVE.
REQ-029 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-030 Any score change SHALL reach the 4-bit output exactly one cycle after the causing pulse.
REQ-031 A miss pulse wider than one cycle SHALL score only once, because the state leaves PLAY after the first cycle.

Reset
REQ-032 While reset=1, at every clk edge: state SHALL be IDLE; scores 0; ball_enable, point_scored, game_over, winner and serve_dir 0; delay counter 0; start edge register 0.
REQ-033 reset SHALL have priority over all other inputs, including when asserted mid-SERVE, mid-PLAY or in OVER.
REQ-034 A start held high through reset release SHALL NOT produce a start edge.

Verification (SERVE_DELAY=4, WIN_SCORE=3)
REQ-035 The bench SHALL check: reset, start 0→1 -> ball_enable=1 exactly 5 cycles after the edge cycle, scores 0/0.
REQ-036 The bench SHALL check: in PLAY, a right_miss pulse -> next cycle leftPlayerScore=1, point_scored=1 for one cycle, serve_dir=1, ball_enable=0; ball_enable=1 again 4 cycles later.
REQ-037 The bench SHALL check: in PLAY, left_miss and right_miss together -> scores unchanged, no point_scored, re-serve after 4 cycles.
REQ-038 The bench SHALL check: three left_miss events, one per PLAY -> rightPlayerScore=3, game_over=1, winner=1; further misses and start-low cycles change nothing.
REQ-039 The bench SHALL check: in OVER, a start edge -> scores 0/0, game_over=0, serve_dir=0, PLAY after 4 cycles.
REQ-040 The bench SHALL check: reset asserted mid-SERVE with start held high -> all outputs 0, IDLE, and no serve until start goes low then high.
